// File: rtl/lbus_arbiter.sv
// lbus_arbiter: two-requester round-robin arbiter and sequencer for the
// 16-bit local bus. Port 0 is the USB command path and port 1 is the
// autonomous acquisition sequencer. Each granted request becomes an
// address phase, a timed strobe phase and a recovery gap. The requester
// gets a one-cycle ack in the first gap cycle. A requester can hold the
// grant across a multi-word burst by setting lock.
module lbus_arbiter #(
  parameter int STB_LEN = 1,
  parameter int GAP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req0_lock,
  output logic        req0_ack,
  output logic [15:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  input  logic        req1_lock,
  output logic        req1_ack,
  output logic [15:0] req1_rdata,
  output logic [15:0] lbus_a,
  output logic [15:0] lbus_di,
  input  logic [15:0] lbus_do,
  output logic        lbus_wrn,
  output logic        lbus_rdn,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_STB  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Phase counters run from 0 up to these terminal values.
  localparam logic [3:0] STB_LAST = 4'(STB_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        grant, grant_n;
  logic        cur_we, cur_we_n;
  logic [15:0] cur_wdata, cur_wdata_n;
  logic        last_grant, last_grant_n;
  logic        lock_set, lock_set_n;
  logic        lock_owner, lock_owner_n;

  logic [15:0] lbus_a_n, lbus_di_n;
  logic        wrn_n, rdn_n;
  logic        ack0_n, ack1_n;
  logic [15:0] rdata0_n, rdata1_n;
  logic        busy_n;

  logic        owner_valid, owner_lock;
  logic        win_valid, win;
  logic        win_we, win_lock;
  logic [15:0] win_addr, win_wdata;

  // Arbitration: a held lock admits only its owner. The lock falls through
  // to round-robin when the owner has neither a request nor a lock pending.
  always_comb begin
    owner_valid = lock_owner ? req1_valid : req0_valid;
    owner_lock  = lock_owner ? req1_lock  : req0_lock;
    win_valid   = 1'b0;
    win         = 1'b0;
    if (lock_set && (owner_valid || owner_lock)) begin
      win_valid = owner_valid;
      win       = lock_owner;
    end else if (req0_valid && req1_valid) begin
      win_valid = 1'b1;
      win       = ~last_grant;
    end else if (req0_valid) begin
      win_valid = 1'b1;
      win       = 1'b0;
    end else if (req1_valid) begin
      win_valid = 1'b1;
      win       = 1'b1;
    end
    win_we    = win ? req1_we    : req0_we;
    win_addr  = win ? req1_addr  : req0_addr;
    win_wdata = win ? req1_wdata : req0_wdata;
    win_lock  = win ? req1_lock  : req0_lock;
  end

  // Next-state and next-output logic. Every output is computed here and
  // then registered, so the lbus pins never see the request inputs directly.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    grant_n      = grant;
    cur_we_n     = cur_we;
    cur_wdata_n  = cur_wdata;
    last_grant_n = last_grant;
    lock_set_n   = lock_set;
    lock_owner_n = lock_owner;
    lbus_a_n     = lbus_a;
    lbus_di_n    = lbus_di;
    wrn_n        = 1'b1;
    rdn_n        = 1'b1;
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;
    rdata0_n     = req0_rdata;
    rdata1_n     = req1_rdata;

    case (state)
      S_IDLE: begin
        if (win_valid) begin
          state_n      = S_ADDR;
          grant_n      = win;
          cur_we_n     = win_we;
          cur_wdata_n  = win_wdata;
          lbus_a_n     = win_addr;
          last_grant_n = win;
          lock_set_n   = win_lock;
          lock_owner_n = win;
        end else begin
          lock_set_n = lock_set && owner_lock;
        end
      end
      S_ADDR: begin
        state_n = S_STB;
        cnt_n   = 4'd0;
        if (cur_we) begin
          wrn_n     = 1'b0;
          lbus_di_n = cur_wdata;
        end else begin
          rdn_n = 1'b0;
        end
      end
      S_STB: begin
        if (cnt == STB_LAST) begin
          state_n = S_GAP;
          cnt_n   = 4'd0;
          ack0_n  = ~grant;
          ack1_n  = grant;
          if (!cur_we) begin
            if (grant) rdata1_n = lbus_do;
            else       rdata0_n = lbus_do;
          end
        end else begin
          cnt_n = cnt + 4'd1;
          wrn_n = ~cur_we;
          rdn_n = cur_we;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = 4'd0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and output registers. Asynchronous reset releases the strobes at
  // once and drops any lock along with the transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      grant      <= 1'b0;
      cur_we     <= 1'b0;
      cur_wdata  <= 16'h0000;
      last_grant <= 1'b1;
      lock_set   <= 1'b0;
      lock_owner <= 1'b0;
      lbus_a     <= 16'h0000;
      lbus_di    <= 16'h0000;
      lbus_wrn   <= 1'b1;
      lbus_rdn   <= 1'b1;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      req0_rdata <= 16'h0000;
      req1_rdata <= 16'h0000;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      cur_we     <= cur_we_n;
      cur_wdata  <= cur_wdata_n;
      last_grant <= last_grant_n;
      lock_set   <= lock_set_n;
      lock_owner <= lock_owner_n;
      lbus_a     <= lbus_a_n;
      lbus_di    <= lbus_di_n;
      lbus_wrn   <= wrn_n;
      lbus_rdn   <= rdn_n;
      req0_ack   <= ack0_n;
      req1_ack   <= ack1_n;
      req0_rdata <= rdata0_n;
      req1_rdata <= rdata1_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: doc/lbus_arbiter.md
Name: lbus_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16-bit local bus that drives the cryptographic FPGA.
- Requester 0 is the USB command path; requester 1 is an on-board autonomous acquisition sequencer.
- Converts single-word read/write requests into timed lbus address/strobe phases and returns read data.
- Round-robin arbitration, with an optional lock for multi-word bursts.

Parameters:
- STB_LEN, 1: strobe (wrn/rdn low) length in clk cycles; legal range 1..15.
- GAP, 1: recovery cycles after a strobe, with both strobes high; legal range 1..15.

Ports:
- clk  in  1  controller clock (divided 3 MHz domain)
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending; held until matching ack
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  16  lbus address
- req0_wdata / req1_wdata  in  16  write data
- req0_lock / req1_lock  in  1  keep grant for next request (burst)
- req0_ack / req1_ack  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  16  read data; valid with ack, held until next read ack on that port
- lbus_a  out  16  address phase bus
- lbus_di  out  16  write data phase bus
- lbus_do  in  16  read data from crypto module
- lbus_wrn  out  1  write strobe, active low
- lbus_rdn  out  1  read strobe, active low
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - lbus_wrn = 1, lbus_rdn = 1.
  - lbus_a = 0, lbus_di = 0.
  - ack0/1 = 0, rdata0/1 = 0, busy = 0.
  - last_grant = 1, lock_owner = none, state = IDLE.
- All outputs are registered. No combinational path from req inputs to lbus outputs.
- FSM states:
  - IDLE: sample valids; pick a grant; latch we/addr/wdata/lock of the winner; go to ADDR. Stay in IDLE if there is no eligible request.
  - ADDR: exactly 1 cycle. lbus_a = latched addr, wrn = rdn = 1. Go to STB.
  - STB: STB_LEN cycles, counted with a 4-bit counter.
    - Write: lbus_di = wdata, wrn = 0.
    - Read: rdn = 0. On the clock edge that ends the last STB cycle, register lbus_do into rdata of the granted port.
    - After the last cycle, go to GAP.
  - GAP: GAP cycles, wrn = rdn = 1. The granted port's ack is high in the first GAP cycle only. After the last GAP cycle, return to IDLE.
- lbus_a and lbus_di keep their last values outside their phases; no tristate.
- Transaction length: 1 (IDLE) + 1 + STB_LEN + GAP cycles. With defaults, 4 cycles from the valid sample edge to the IDLE return.
- Arbitration in IDLE:
  - If lock_owner is set: only the owner is eligible.
    - Owner valid: it is granted.
    - Owner lock low and owner valid low: lock releases (lock_owner = none) and normal arbitration runs in the same cycle.
  - Otherwise: single valid wins. If both are valid, the port != last_grant wins. last_grant updates on every grant.
  - lock_owner is set when the granted request has lock = 1. It is cleared when a granted request from the owner has lock = 0; that request is the last of the burst.
- Requester rule: valid may be re-asserted with a new request in the cycle after ack; it is sampled at the next IDLE. The arbiter ignores valid/data changes while not in IDLE (latched copies are used).
- Both valid with neither locked: strictly alternate grants, no starvation.
- valid dropped before grant is legal (request withdrawn). valid dropped after grant does not abort the transaction; the ack is still issued.
- Reset mid-transaction: strobes return to 1 immediately (asynchronous), the transaction is lost, no ack is issued, and any lock is released.

Test Plan:
1. Port0 write addr 0x0002, data 0xA5A5, defaults -> ADDR with lbus_a = 0x0002 for 1 cycle; next cycle wrn = 0, lbus_di = 0xA5A5 for 1 cycle; ack0 in the following cycle; busy high for 3 cycles.
2. Port1 read addr 0x000C, lbus_do = 0x1234 during strobe, STB_LEN = 3 -> rdn low for exactly 3 cycles; ack1 with rdata1 = 0x1234; rdata1 still 0x1234 after a later port0 transaction.
3. Both ports valid continuously, no lock -> grant order 0,1,0,1 after reset; each ack only to the granted port; lbus strobes never overlap.
4. Port1 burst of 3 writes (lock = 1,1,0) while port0 is valid -> all 3 port1 writes complete before port0 is granted; port0 is then granted next.
5. Owner drops lock and valid with no further request, port0 pending -> lock releases and port0 is granted in the same IDLE cycle.
6. Assert rst during the STB of a write -> wrn = 1 within the same cycle, no ack; after reset, port0 wins a simultaneous request.
